// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: one bit position per clock under a start/busy/done handshake.
// Supports logical right/left, arithmetic right and rotate left by a programmable amount.
module seq_shift_unit #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SHAMT_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   din,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   dout
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StShift = 2'b01,
      StDone  = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      ModeLsr = 2'b00,
      ModeLsl = 2'b01,
      ModeAsr = 2'b10,
      ModeRol = 2'b11
   } mode_e;

   localparam logic [SHAMT_W-1:0] CountOne = SHAMT_W'(1);

   state_e             state_q, state_d;
   mode_e              mode_q, mode_d;
   logic [SHAMT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic [WIDTH-1:0]   step_val;

   // Single-position step of the working register for the latched mode.
   always_comb begin
      step_val = work_q;
      case (mode_q)
         ModeLsr: step_val = {1'b0, work_q[WIDTH-1:1]};
         ModeLsl: step_val = {work_q[WIDTH-2:0], 1'b0};
         ModeAsr: step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         ModeRol: step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
         default: step_val = work_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      count_d = count_q;
      work_d  = work_q;
      dout_d  = dout_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               mode_d  = mode_e'(mode);
               count_d = shamt;
               work_d  = din;
               if (shamt == '0) begin
                  // Zero amount: result is the operand, skip SHIFT entirely.
                  state_d = StDone;
                  dout_d  = din;
               end else begin
                  state_d = StShift;
               end
            end
         end
         StShift: begin
            work_d  = step_val;
            count_d = count_q - CountOne;
            if (count_q == CountOne) begin
               state_d = StDone;
               dout_d  = step_val;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         mode_q  <= ModeLsr;
         count_q <= '0;
         work_q  <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         work_q  <= work_d;
         dout_q  <= dout_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);
   assign dout = dout_q;

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Parameterised, multi-cycle shift engine. Generalises the single-bit right shift to four modes, a programmable shift amount and any data width.
- Shifts one bit position per clock under a start/busy/done handshake, then holds the result in a register.
- Sits beside the datapath as a small area-cheap shifter for ALU-style blocks where latency is acceptable.

Parameters:
- WIDTH, 8, data width in bits (>=2).
- SHAMT_W, 3, width of the shift-amount input. Amounts up to 2^SHAMT_W-1 are legal, including amounts >= WIDTH.

Ports:
- clk    input   1          rising-edge clock; the only clock.
- rst    input   1          synchronous, active-high reset.
- start  input   1          request; sampled only in IDLE.
- mode   input   2          00=logical right, 01=logical left, 10=arithmetic right, 11=rotate left.
- shamt  input   SHAMT_W    shift amount, unsigned.
- din    input   WIDTH      operand.
- busy   output  1          high whenever state != IDLE.
- done   output  1          one-cycle pulse; dout valid.
- dout   output  WIDTH      registered result; held until the next completion.

Behaviour:
- One clock; reset is synchronous and active-high, ports clk and rst. All state changes occur on the rising edge of clk.
- Reset (any state, including mid-operation): state=IDLE, busy=0, done=0, dout=0, internal count=0, working register=0. Any in-flight operation is discarded, with no done.
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - On an edge with start=1: latch din into the working register, shamt into the count, mode into the mode register.
  - Next state is SHIFT if shamt!=0, else DONE.
  - start=0: remain in IDLE.
- SHIFT
  - Each edge shifts the working register by exactly one position per the latched mode, and decrements the count.
  - When the count reaches 0 on that edge, next state is DONE.
- DONE
  - done=1 for exactly this one cycle. dout was loaded with the final working value on the edge entering DONE.
  - Next edge returns to IDLE unconditionally.
- Per-step mode semantics:
  - Logical right: shift in 0 at the MSB.
  - Logical left: shift in 0 at the LSB.
  - Arithmetic right: replicate the MSB.
  - Rotate left: MSB wraps to the LSB.
- Latency:
  - With the start edge as E0, done is high in the cycle after edge E0+max(shamt,0). shamt=0 gives done the cycle after E0; shamt=k gives done after E0+k.
  - busy rises after E0 and falls after the DONE cycle.
  - Throughput is one operation per shamt+2 cycles.
- Handshake rules:
  - start is ignored while busy=1, including in the DONE cycle. Such a request is lost, and the caller must re-assert.
  - Changes to mode, shamt or din while busy have no effect.
- Width and amount boundaries:
  - shamt >= WIDTH is legal and iterates fully.
  - Logical shifts give all zeros.
  - Arithmetic right gives all copies of the sign bit.
  - Rotate left gives rotation by shamt mod WIDTH.
- dout changes only on entry to DONE or on reset. It is never transiently updated during SHIFT.

Test Plan:
- WIDTH=8: din=8'b10011001, mode=00, shamt=1, start pulse -> done after 1 edge, dout=8'b01001100, busy high 2 cycles.
- din=8'b10011001, mode=10, shamt=3 -> dout=8'b11110011 after 3 edges. Same din, mode=11, shamt=3 -> dout=8'b11001100. Same din, mode=01, shamt=2 -> dout=8'b01100100.
- shamt=0, mode=01, din=8'hA5 -> done the cycle after the start edge, dout=8'hA5, no SHIFT cycles.
- SHAMT_W=4 instance: din=8'h81, shamt=9. mode=00 -> dout=8'h00. mode=10 -> dout=8'hFF. mode=11 -> dout=8'h03. Each completes after 9 edges.
- Start a shamt=5 operation. Pulse start with din=8'hFF in cycles 2 and in DONE -> both ignored. Only the first result is produced, and exactly one done pulse occurs.
- Assert rst during SHIFT of a shamt=6 operation -> next cycle busy=0, done=0, dout=0, with no done pulse thereafter. A new start after reset completes normally.
